// File: rtl/up_fetch_seq.sv
// rtl/up_fetch_seq.sv - nibble-processor PC, fetch/execute phase, fetch register, optional return stack (UP_FETCH_CALL_STACK_EN)
module up_fetch_seq #(
    parameter int ADDR_W      = 12,
    parameter int INSTR_W     = 8,
    parameter int OPRND_W     = 4,
    parameter int STACK_DEPTH = 4
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             stall,
    input  logic [INSTR_W-1:0]               program_byte,
    input  logic                             inc,
    input  logic                             load,
    input  logic                             call,
    input  logic                             ret,
    input  logic [ADDR_W-1:0]                load_addr,
    output logic [ADDR_W-1:0]                PC,
    output logic                             phase,
    output logic [INSTR_W-OPRND_W-1:0]       instr,
    output logic [OPRND_W-1:0]               oprnd,
    output logic [$clog2(STACK_DEPTH+1)-1:0] sp,
    output logic                             stack_err
);

    logic [ADDR_W-1:0] pc_inc;
    assign pc_inc = PC + ADDR_W'(1);

`ifdef UP_FETCH_CALL_STACK_EN
    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int PTR_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

    logic [ADDR_W-1:0] stack_mem [2**PTR_W];
    logic [SP_W-1:0]   sp_dec;
    assign sp_dec = sp - SP_W'(1);

    always_ff @(posedge clock) begin
        if (reset) begin
            PC        <= '0;
            phase     <= 1'b0;
            instr     <= '0;
            oprnd     <= '0;
            sp        <= '0;
            stack_err <= 1'b0;
        end else if (!stall) begin
            if (!phase) begin
                {instr, oprnd} <= program_byte;
                PC             <= pc_inc;
                phase          <= 1'b1;
            end else begin
                phase <= 1'b0;
                if (ret) begin
                    if (sp != '0) begin
                        PC <= stack_mem[sp_dec[PTR_W-1:0]];
                        sp <= sp_dec;
                    end else begin
                        stack_err <= 1'b1;
                    end
                end else if (call) begin
                    // The jump is taken even when the push has to be dropped
                    PC <= load_addr;
                    if (sp == SP_FULL) begin
                        stack_err <= 1'b1;
                    end else begin
                        stack_mem[sp[PTR_W-1:0]] <= pc_inc;
                        sp                       <= sp + SP_W'(1);
                    end
                end else if (load) begin
                    PC <= load_addr;
                end else if (inc) begin
                    PC <= pc_inc;
                end
            end
        end
    end
`else
    logic unused_ret;
    assign unused_ret = ret;
    assign sp         = '0;
    assign stack_err  = 1'b0;

    always_ff @(posedge clock) begin
        if (reset) begin
            PC    <= '0;
            phase <= 1'b0;
            instr <= '0;
            oprnd <= '0;
        end else if (!stall) begin
            if (!phase) begin
                {instr, oprnd} <= program_byte;
                PC             <= pc_inc;
                phase          <= 1'b1;
            end else begin
                phase <= 1'b0;
                if (call || load) begin
                    PC <= load_addr;
                end else if (inc) begin
                    PC <= pc_inc;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_up_fetch_seq.sv
// tb/tb_up_fetch_seq.sv - directed self-checking bench for up_fetch_seq, both UP_FETCH_CALL_STACK_EN builds
module tb_up_fetch_seq;

    logic        clock = 1'b0;
    logic        reset, stall, inc, load, call, ret;
    logic [7:0]  program_byte;
    logic [11:0] load_addr, PC;
    logic        phase;
    logic [3:0]  instr, oprnd;
    logic [2:0]  sp;
    logic        stack_err;

    logic [7:0]  rom [4096];
    int          passed = 0;
    int          total  = 0;

`ifdef UP_FETCH_CALL_STACK_EN
    localparam bit STK = 1'b1;
`else
    localparam bit STK = 1'b0;
`endif

    always #5 clock = ~clock;

    assign program_byte = rom[PC];

    up_fetch_seq dut (
        .clock(clock), .reset(reset), .stall(stall), .program_byte(program_byte),
        .inc(inc), .load(load), .call(call), .ret(ret), .load_addr(load_addr),
        .PC(PC), .phase(phase), .instr(instr), .oprnd(oprnd), .sp(sp), .stack_err(stack_err)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic do_reset();
        reset = 1'b1; stall = 1'b0; inc = 1'b0; load = 1'b0; call = 1'b0; ret = 1'b0;
        step();
        reset = 1'b0;
    endtask

    // From a fresh reset, land in an execute cycle with PC == a
    task automatic goto_exec(input logic [11:0] a);
        step();
        load = 1'b1; load_addr = a - 12'd1;
        step();
        load = 1'b0;
        step();
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) rom[i] = 8'(i * 37 + 11);
        rom[0] = 8'h12; rom[1] = 8'h34; rom[2] = 8'h56; rom[3] = 8'h78;
        load_addr = '0;

        do_reset();
        chk("rst_pc", PC, 0); chk("rst_phase", phase, 0); chk("rst_instr", instr, 0);
        chk("rst_oprnd", oprnd, 0); chk("rst_sp", sp, 0); chk("rst_err", stack_err, 0);

        // free run
        step(); chk("run_pc1", PC, 1); chk("run_ph1", phase, 1); chk("run_byte0", {instr, oprnd}, 8'h12);
        step(); chk("run_pc1b", PC, 1); chk("run_ph0", phase, 0); chk("run_hold0", {instr, oprnd}, 8'h12);
        step(); chk("run_pc2", PC, 2); chk("run_byte1", {instr, oprnd}, 8'h34);
        step(); chk("run_pc2b", PC, 2);

        // inc then load
        step(); chk("inc_pre", PC, 3);
        inc = 1'b1; step(); inc = 1'b0;
        chk("inc_pc", PC, 4); chk("inc_ph", phase, 0);
        step(); chk("ld_pre", PC, 5);
        load = 1'b1; load_addr = 12'h0A5; step(); load = 1'b0;
        chk("ld_pc", PC, 12'h0A5); chk("ld_ph", phase, 0);

        // call / ret
        do_reset(); goto_exec(12'h010);
        chk("call_pre", PC, 12'h010); chk("call_pre_ph", phase, 1);
        call = 1'b1; load_addr = 12'h100; step(); call = 1'b0;
        chk("call_pc", PC, 12'h100); chk("call_sp", sp, STK ? 1 : 0);
        step(); chk("ret_pre", PC, 12'h101);
        ret = 1'b1; step(); ret = 1'b0;
        chk("ret_pc", PC, STK ? 12'h011 : 12'h101); chk("ret_sp", sp, 0);

        // nested calls up to overflow, then LIFO pop
        do_reset(); goto_exec(12'h020);
        for (int k = 0; k < 5; k++) begin
            call = 1'b1; load_addr = 12'h200 + 12'(k * 16); step(); call = 1'b0;
            if (k == 3) begin
                chk("nest4_sp", sp, STK ? 4 : 0); chk("nest4_err", stack_err, 0);
            end
            if (k < 4) step();
        end
        chk("ovf_pc", PC, 12'h240); chk("ovf_sp", sp, STK ? 4 : 0); chk("ovf_err", stack_err, STK ? 1 : 0);
        step();
        ret = 1'b1; step(); ret = 1'b0;
        chk("pop_pc", PC, STK ? 12'h222 : 12'h241); chk("pop_sp", sp, STK ? 3 : 0);

        // underflow, sticky error, ret+call together
        do_reset(); goto_exec(12'h030);
        ret = 1'b1; step(); ret = 1'b0;
        chk("unf_pc", PC, 12'h030); chk("unf_err", stack_err, STK ? 1 : 0); chk("unf_sp", sp, 0);
        step(); chk("unf_sticky", stack_err, STK ? 1 : 0);
        call = 1'b1; load_addr = 12'h300; step(); call = 1'b0;
        chk("rc_call_sp", sp, STK ? 1 : 0);
        step();
        ret = 1'b1; call = 1'b1; load_addr = 12'h3AA; step(); ret = 1'b0; call = 1'b0;
        chk("rc_pc", PC, STK ? 12'h032 : 12'h3AA); chk("rc_sp", sp, 0);

        // reset during stall
        stall = 1'b1; reset = 1'b1; step(); reset = 1'b0; stall = 1'b0;
        chk("srst_pc", PC, 0); chk("srst_ph", phase, 0); chk("srst_instr", {instr, oprnd}, 0);
        chk("srst_err", stack_err, 0); chk("srst_sp", sp, 0);

        // stall mid-execute with load pending
        do_reset(); goto_exec(12'h040);
        load = 1'b1; load_addr = 12'h0C3; stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("stl_pc", PC, 12'h040); chk("stl_ph", phase, 1); chk("stl_byte", {instr, oprnd}, rom[12'h03F]);
        end
        stall = 1'b0; step(); load = 1'b0;
        chk("stl_jump", PC, 12'h0C3); chk("stl_ph0", phase, 0);
        stall = 1'b1; step(); stall = 1'b0;
        chk("stlf_pc", PC, 12'h0C3); chk("stlf_ph", phase, 0);
        step(); chk("stlf_resume", PC, 12'h0C4); chk("stlf_byte", {instr, oprnd}, rom[12'h0C3]);

        // PC wrap
        do_reset(); goto_exec(12'hFFE);
        inc = 1'b1; step(); inc = 1'b0;
        chk("wrap_pre", PC, 12'hFFF);
        step(); chk("wrap_pc", PC, 12'h000); chk("wrap_byte", {instr, oprnd}, rom[12'hFFF]);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
